// File: rtl/core_branch_sched_pkg.sv
// Shared types and defaults for the branch-unit issue controller.
// Reuses the core's insn_decode/hword/hptr shapes unchanged.
package core_branch_sched_pkg;

  typedef logic [15:0] hword;
  typedef logic [31:0] hptr;

  typedef struct packed {
    logic [3:0]  op;
    logic [3:0]  rd;
    logic [3:0]  rs1;
    logic [3:0]  rs2;
    logic [15:0] imm;
  } insn_decode;

  typedef enum logic [1:0] {
    BS_IDLE,
    BS_WAIT,
    BS_RESOLVE,
    BS_FLUSH
  } branch_sched_state;

  localparam int BRANCH_FLUSH_CYCLES = 2;
  localparam int FLUSH_CNT_W         = 4;

  // A source register still awaiting a pending write blocks issue.
  function automatic logic has_hazard(input hword src, input hword pending);
    return |(src & pending);
  endfunction

endpackage

// File: rtl/core_branch_sched_stats.sv
// Taken / not-taken resolution counters, wrapping modulo 2^STAT_W.
// Only instantiated when CORE_BRANCH_SCHED_STATS_EN is defined.
module core_branch_sched_stats #(
  parameter int STAT_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              inc_taken,
  input  logic              inc_not_taken,
  output logic [STAT_W-1:0] stat_taken,
  output logic [STAT_W-1:0] stat_not_taken
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_taken     <= '0;
      stat_not_taken <= '0;
    end else begin
      if (inc_taken)
        stat_taken <= stat_taken + STAT_W'(1);
      if (inc_not_taken)
        stat_not_taken <= stat_not_taken + STAT_W'(1);
    end
  end

endmodule

// File: rtl/core_branch_sched.sv
// Branch-unit issue controller: holds one branch until RAW-hazard free, issues it,
// and turns a taken resolution into a redirect pulse plus a fixed-length flush.
// Optional statistics counters: define CORE_BRANCH_SCHED_STATS_EN.
module core_branch_sched
  import core_branch_sched_pkg::*;
#(
  parameter int FLUSH_CYCLES = BRANCH_FLUSH_CYCLES,
  parameter int STAT_W       = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  insn_decode        in_dec,
  input  hword              src_mask,
  input  hword              busy_mask,
  input  logic              wb_stall,
  input  logic              kill,
  output insn_decode        dec,
  output logic              start,
  input  logic              unit_branch,
  input  hptr               unit_target,
  output logic              flush,
  output logic              redirect_valid,
  output hptr               redirect_pc,
  output logic              busy,
  output logic [STAT_W-1:0] stat_taken,
  output logic [STAT_W-1:0] stat_not_taken
);

  branch_sched_state        state;
  branch_sched_state        state_nxt;
  insn_decode               hold_dec;
  hword                     hold_src;
  hptr                      pc_q;
  logic [FLUSH_CNT_W-1:0]   flush_cnt;
  logic                     accept;
  logic                     resolve_taken;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      state <= BS_IDLE;
    else
      state <= state_nxt;
  end

  // kill wins over everything, including a transfer offered in the same cycle.
  always_comb begin
    state_nxt     = state;
    in_ready      = 1'b0;
    accept        = 1'b0;
    start         = 1'b0;
    resolve_taken = 1'b0;
    case (state)
      BS_IDLE: begin
        in_ready = !kill;
        if (in_valid && !kill) begin
          accept    = 1'b1;
          state_nxt = BS_WAIT;
        end
      end
      BS_WAIT: begin
        if (!kill && !wb_stall && !has_hazard(hold_src, busy_mask)) begin
          start     = 1'b1;
          state_nxt = BS_RESOLVE;
        end
      end
      BS_RESOLVE: begin
        if (unit_branch) begin
          resolve_taken = !kill;
          state_nxt     = BS_FLUSH;
        end else begin
          state_nxt = BS_IDLE;
        end
      end
      BS_FLUSH: begin
        if (flush_cnt <= FLUSH_CNT_W'(1))
          state_nxt = BS_IDLE;
      end
      default: state_nxt = BS_IDLE;
    endcase
    if (kill)
      state_nxt = BS_IDLE;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold_dec <= '0;
      hold_src <= '0;
    end else if (kill) begin
      hold_dec <= '0;
      hold_src <= '0;
    end else if (accept) begin
      hold_dec <= in_dec;
      hold_src <= src_mask;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q      <= '0;
      flush_cnt <= '0;
    end else begin
      if (resolve_taken) begin
        pc_q      <= unit_target;
        flush_cnt <= FLUSH_CNT_W'(FLUSH_CYCLES);
      end else if (kill) begin
        flush_cnt <= '0;
      end else if (state == BS_FLUSH) begin
        flush_cnt <= flush_cnt - FLUSH_CNT_W'(1);
      end
    end
  end

  // The target is forwarded during RESOLVE so the redirect pulse carries it.
  assign redirect_valid = resolve_taken;
  assign redirect_pc    = (state == BS_RESOLVE) ? unit_target : pc_q;
  assign flush          = (state == BS_FLUSH);
  assign busy           = (state != BS_IDLE);
  assign dec            = hold_dec;

`ifdef CORE_BRANCH_SCHED_STATS_EN
  logic resolve_not_taken;
  assign resolve_not_taken = (state == BS_RESOLVE) && !kill && !unit_branch;

  core_branch_sched_stats #(
    .STAT_W (STAT_W)
  ) u_stats (
    .clk            (clk),
    .rst_n          (rst_n),
    .inc_taken      (resolve_taken),
    .inc_not_taken  (resolve_not_taken),
    .stat_taken     (stat_taken),
    .stat_not_taken (stat_not_taken)
  );
`else
  assign stat_taken     = '0;
  assign stat_not_taken = '0;
`endif

endmodule

// File: doc/core_branch_sched.md
# core_branch_sched

Issue controller for the branch unit. Sits between decode and `core_branch`. It accepts one decoded control-flow instruction at a time and holds it until its source registers are free of RAW hazards. It then pulses the branch unit's `start`, samples the resolution one cycle later, and on a taken branch drives a fixed-length pipeline flush plus a fetch redirect.

## Interface
Parameters:
- FLUSH_CYCLES, 2, number of cycles `flush` stays high after a taken branch (legal 1..15)
- STAT_W, 32, width of each statistics counter (only used with the stats feature)

Ports:
- clk  in  1  core clock
- rst_n  in  1  reset; one clock, reset is asynchronous and active-low
- in_valid  in  1  decode offers a branch instruction
- in_ready  out  1  controller can accept; transfer when in_valid && in_ready
- in_dec  in  insn_decode  decoded instruction captured on transfer
- src_mask  in  hword  one-hot-per-register source set of the offered instruction
- busy_mask  in  hword  scoreboard pending-write mask, combined with the branch unit's raw_mask
- wb_stall  in  1  writeback back-pressure; no issue while high
- kill  in  1  higher-priority squash (exception/interrupt)
- dec  out  insn_decode  held instruction, to branch unit
- start  out  1  one-cycle issue pulse to branch unit
- unit_branch  in  1  branch unit's `branch` output
- unit_target  in  hptr  branch unit's `target` output
- flush  out  1  squash younger instructions
- redirect_valid  out  1  one-cycle fetch redirect pulse
- redirect_pc  out  hptr  redirect target, halfword pointer
- busy  out  1  state != IDLE
- stat_taken, stat_not_taken  out  STAT_W  resolution counters (stats feature only)

## Operation
- States: IDLE, WAIT, RESOLVE, FLUSH.
- IDLE: in_ready=1. On transfer: latch in_dec and src_mask into hold registers, go to WAIT.
- WAIT: hazard = |(hold_src & busy_mask). When !hazard && !wb_stall && !kill: start=1 this cycle, go to RESOLVE. Otherwise stay, start=0.
- RESOLVE (exactly one cycle): sample unit_branch.
  - unit_branch=1: latch unit_target into redirect_pc, pulse redirect_valid in the same cycle, load flush counter with FLUSH_CYCLES, go to FLUSH.
  - unit_branch=0: go to IDLE.
- FLUSH: flush=1. Counter decrements each cycle; at 1, go to IDLE.
- kill in any state: next state IDLE, hold cleared. kill in RESOLVE suppresses redirect_valid and stats update. kill overrides a same-cycle transfer (in_ready is forced to 0 when kill=1).
- in_ready=0 in WAIT, RESOLVE and FLUSH. No back-to-back acceptance; the earliest accept after RESOLVE is the following IDLE cycle.
- `dec` reflects the hold register in all states. Its value in IDLE is don't-care.
- A busy_mask change during WAIT is re-evaluated every cycle. No hazard latching.

## Timing
- Reset values: state=IDLE, in_ready=1, start=0, flush=0, redirect_valid=0, redirect_pc=0, busy=0, stat counters=0.
- Minimum latency from transfer (cycle T) to start: T+1. Resolution is sampled at T+2; redirect_valid is at T+2; flush runs T+3..T+2+FLUSH_CYCLES.
- start is never high for two consecutive cycles.
- Reset asserted mid-operation: all outputs return to reset values asynchronously; the held instruction is lost.
- Stats counters wrap modulo 2^STAT_W.

## Configuration
- CORE_BRANCH_SCHED_STATS_EN defined: stat_taken increments on each non-killed RESOLVE with unit_branch=1; stat_not_taken increments on each non-killed RESOLVE with unit_branch=0.
- CORE_BRANCH_SCHED_STATS_EN undefined: stat ports are still present but tied to 0, with no counter flops.

## Structure
- Shared package (core/uarch.sv): `branch_sched_state` enum typedef and a `BRANCH_FLUSH_CYCLES` default constant. The existing insn_decode, hword and hptr types are reused unchanged.
- One sub-module, `core_branch_sched_stats`: the two wrapping counters. It is instantiated only under the macro.

## Test plan
- Reset, then a transfer with src_mask=0x0004, busy_mask=0 → start at T+1; unit_branch=0 at T+2 → IDLE at T+3, flush never high, stat_not_taken=1.
- busy_mask=0x0004 for 3 cycles after the transfer → start is delayed to the first cycle busy_mask bit 2 clears, and is exactly one cycle wide.
- Taken branch with unit_target=0x0000_1000 → redirect_valid for one cycle with redirect_pc=0x1000, flush high for exactly 2 cycles, in_ready low throughout, stat_taken=1.
- kill asserted in RESOLVE with unit_branch=1 → no redirect_valid, no flush, state IDLE next cycle, counters unchanged.
- wb_stall held high in WAIT for 4 cycles with no hazard → no start until wb_stall drops, then start the next cycle.
- rst_n pulled low during FLUSH → flush, busy and redirect_valid drop immediately; after release in_ready=1.
